// File: rtl/solucao_int_mux_pkg.sv
// Shared definitions for the 4-channel interrupt selector.
// Mode encodings, channel indices and the one-hot test used by the select check.
package solucao_pkg;

  localparam logic MODE_SEL    = 1'b1;
  localparam logic MODE_BYPASS = 1'b0;

  localparam int CH_A = 0;
  localparam int CH_B = 1;
  localparam int CH_C = 2;
  localparam int CH_D = 3;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  function automatic logic onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/solucao_int_mux_sync2.sv
// Single-bit two-flop synchronizer, cleared to 0 by an asynchronous active-high reset.
module solucao_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; only sync_q is safe to use downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/solucao_int_mux.sv
// Clocked 4-channel interrupt selector with a registered request output and an
// illegal-select flag. Build option SOLUCAO_INT_SYNC_EN inserts a two-flop
// synchronizer on each interrupt input (interrupt latency 3 cycles instead of 1;
// mode/select latency stays 1 cycle).
module solucao_int_mux
  import solucao_pkg::*;
#(
  parameter logic RST_Y = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic m,
  input  logic inta,
  input  logic intb,
  input  logic intc,
  input  logic intd,
  input  logic sa,
  input  logic sb,
  input  logic sc,
  input  logic sd,
  output logic y,
  output logic sel_err
);

  logic [3:0] int_raw;
  logic [3:0] int_s;
  logic [3:0] sel;
  logic       y_d, y_q;
  logic       sel_err_d, sel_err_q;

  assign int_raw[CH_A] = inta;
  assign int_raw[CH_B] = intb;
  assign int_raw[CH_C] = intc;
  assign int_raw[CH_D] = intd;

  assign sel[CH_A] = sa;
  assign sel[CH_B] = sb;
  assign sel[CH_C] = sc;
  assign sel[CH_D] = sd;

`ifdef SOLUCAO_INT_SYNC_EN
  for (genvar g = 0; g < 4; g++) begin : g_sync
    solucao_sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (int_raw[g]),
      .q_o (int_s[g])
    );
  end
`else
  assign int_s = int_raw;
`endif

  // Next output: OR of selected channels in select mode, channel A in bypass.
  always_comb begin
    y_d       = 1'b0;
    sel_err_d = 1'b0;
    case (m)
      MODE_SEL: begin
        y_d       = |(int_s & sel);
        sel_err_d = ~onehot4(sel);
      end
      MODE_BYPASS: begin
        y_d       = int_s[CH_A];
        sel_err_d = 1'b0;
      end
    endcase
  end

  // Output register; only changes on the clock edge so select changes cannot glitch y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q       <= RST_Y;
      sel_err_q <= 1'b0;
    end else begin
      y_q       <= y_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign y       = y_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_solucao_int_mux.sv
// Self-checking bench for solucao_int_mux: behavioural model compared every
// cycle, plus directed vectors with hand-computed expectations.
module tb_solucao_int_mux;

`ifdef SOLUCAO_INT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  logic m, inta, intb, intc, intd, sa, sb, sc, sd;
  logic y, sel_err;

  int checks = 0;
  int errors = 0;

  solucao_int_mux dut (
    .clk     (clk),
    .rst     (rst),
    .m       (m),
    .inta    (inta),
    .intb    (intb),
    .intc    (intc),
    .intd    (intd),
    .sa      (sa),
    .sb      (sb),
    .sc      (sc),
    .sd      (sd),
    .y       (y),
    .sel_err (sel_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: expected outputs from the selection rules.
  logic       exp_y, exp_err;
  logic [3:0] h1, h2;
  logic       model_on = 1'b0;

  always @(posedge clk or posedge rst) begin
    logic [3:0] ints, sels, eff;
    logic       acc;
    if (rst) begin
      exp_y   = 1'b0;
      exp_err = 1'b0;
      h1      = 4'b0;
      h2      = 4'b0;
    end else begin
      ints = {intd, intc, intb, inta};
      sels = {sd, sc, sb, sa};
`ifdef SOLUCAO_INT_SYNC_EN
      eff = h2;
      h2  = h1;
      h1  = ints;
`else
      eff = ints;
`endif
      if (m) begin
        acc = 1'b0;
        for (int i = 0; i < 4; i++) if (sels[i] && eff[i]) acc = 1'b1;
        exp_y   = acc;
        exp_err = ($countones(sels) != 1);
      end else begin
        exp_y   = eff[0];
        exp_err = 1'b0;
      end
    end
  end

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    if (model_on) begin
      chk("model_y", y, exp_y);
      chk("model_sel_err", sel_err, exp_err);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic [3:0] ints, input logic [3:0] sels, input logic mode);
    {intd, intc, intb, inta} = ints;
    {sd, sc, sb, sa}         = sels;
    m                        = mode;
  endtask

  initial begin
    logic [3:0] chsel [3];
    chsel[0] = 4'b0100;
    chsel[1] = 4'b0010;
    chsel[2] = 4'b0001;

    // Reset with arbitrary inputs
    rst = 1'b1;
    set_in(4'b1111, 4'b0011, 1'b1);
    #1;
    chk("rst_y_immediate", y, 1'b0);
    chk("rst_err_immediate", sel_err, 1'b0);
    model_on = 1'b1;
    cyc(2);
    chk("rst_y_hold", y, 1'b0);
    chk("rst_err_hold", sel_err, 1'b0);

    // Release between edges: no update until next edge
    set_in(4'b0001, 4'b0000, 1'b0);
    rst = 1'b0;
    #1;
    chk("release_no_update", y, 1'b0);
    cyc(LAT);
    chk("release_first_edge", y, 1'b1);

    // Select mode, channel D
    set_in(4'b0000, 4'b1000, 1'b1);
    cyc(LAT);
    chk("chd_y0", y, 1'b0);
    chk("chd_err", sel_err, 1'b0);
    intd = 1'b1;
    if (LAT > 1) cyc(LAT - 1);
    #1;
    chk("chd_y_before_latency", y, 1'b0);
    cyc(1);
    chk("chd_y1", y, 1'b1);
    chk("chd_err1", sel_err, 1'b0);

    // Walk selects C, B, A with the other interrupts held high
    for (int k = 0; k < 3; k++) begin
      set_in(~chsel[k], chsel[k], 1'b1);
      cyc(LAT);
      chk("walk_y_low", y, 1'b0);
      chk("walk_err", sel_err, 1'b0);
      set_in(4'b1111, chsel[k], 1'b1);
      cyc(LAT);
      chk("walk_y_high", y, 1'b1);
      set_in(~chsel[k], chsel[k], 1'b1);
      cyc(LAT);
      chk("walk_y_low_again", y, 1'b0);
    end

    // Bypass: selects and B..D ignored
    set_in(4'b1110, 4'b1000, 1'b0);
    cyc(LAT);
    chk("bypass_y0", y, 1'b0);
    chk("bypass_err", sel_err, 1'b0);
    inta = 1'b1;
    cyc(LAT);
    chk("bypass_y1", y, 1'b1);
    set_in(4'b0001, 4'b0000, 1'b0);
    cyc(1);
    chk("bypass_err_nosel", sel_err, 1'b0);

    // Illegal selects
    set_in(4'b1111, 4'b0000, 1'b1);
    cyc(LAT);
    chk("illegal_none_y", y, 1'b0);
    chk("illegal_none_err", sel_err, 1'b1);
    set_in(4'b0010, 4'b0011, 1'b1);
    cyc(LAT);
    chk("illegal_two_y", y, 1'b1);
    chk("illegal_two_err", sel_err, 1'b1);

    // Async reset mid-cycle
    rst = 1'b1;
    #1;
    chk("async_rst_y", y, 1'b0);
    chk("async_rst_err", sel_err, 1'b0);
    cyc(1);
    rst = 1'b0;

    // Single-cycle inta pulse in bypass appears LAT cycles later
    set_in(4'b0000, 4'b0000, 1'b0);
    cyc(LAT + 1);
    inta = 1'b1;
    cyc(1);
    inta = 1'b0;
    if (LAT > 1) cyc(LAT - 1);
    chk("pulse_y_high", y, 1'b1);
    cyc(1);
    chk("pulse_y_low", y, 1'b0);

    cyc(2);
    model_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
